// File: rtl/regs_pkg.sv
// Shared definitions for the operand register writeback path: data width,
// destination encodings, flag bit positions and the buffered beat format.
package regs_pkg;

  localparam int WIDTH = 8;

  localparam logic [1:0] DEST_NONE = 2'b00;
  localparam logic [1:0] DEST_A    = 2'b01;
  localparam logic [1:0] DEST_B    = 2'b10;
  localparam logic [1:0] DEST_AB   = 2'b11;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // One writeback beat exactly as it arrives from the ALU
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       dest;
    logic [3:0]       flags;
    logic             flags_en;
  } wb_entry_t;

  function automatic logic dest_writes_a(input logic [1:0] dest);
    return (dest == DEST_A) || (dest == DEST_AB);
  endfunction

  function automatic logic dest_writes_b(input logic [1:0] dest);
    return (dest == DEST_B) || (dest == DEST_AB);
  endfunction

endpackage

// File: rtl/wb_hold_buffer.sv
// Single-entry holding buffer for a writeback beat that arrives while commit
// is stalled. A full buffer is never overwritten; consume wins over load.
module wb_hold_buffer
  import regs_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load,
  input  logic      consume,
  input  wb_entry_t din,
  output wb_entry_t dout,
  output logic      full
);

  // Capture a beat into an empty slot, release it when the top commits it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      dout <= '0;
    end else if (consume) begin
      full <= 1'b0;
    end else if (load && !full) begin
      full <= 1'b1;
      dout <= din;
    end
  end

endmodule

// File: rtl/regs_ab_writeback.sv
// Write side of the A/B operand registers and flag register. Beats arrive
// over valid/ready, commit immediately when commit_en is high, otherwise park
// in a one-entry holding buffer. clr_a overrides any A write on its edge.
module regs_ab_writeback #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [WIDTH-1:0] wb_data,
  input  logic [1:0]       wb_dest,
  input  logic [3:0]       wb_flags,
  input  logic             wb_flags_en,
  input  logic             commit_en,
  input  logic             clr_a,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [3:0]       flags_out,
  output logic             a_zero,
  output logic             hold_full,
  output logic [CNT_W-1:0] commit_count
);

  import regs_pkg::*;

  wb_entry_t in_entry;
  wb_entry_t held_entry;
  wb_entry_t commit_entry;
  logic      accept;
  logic      consume_hold;
  logic      load_hold;
  logic      do_commit;

  // Ready depends only on reset and the registered buffer state
  assign wb_ready = rst_n & ~hold_full;
  assign accept   = wb_valid & wb_ready;

  assign in_entry = '{data: wb_data, dest: wb_dest, flags: wb_flags, flags_en: wb_flags_en};

  // A held beat always commits first; ready is low then, so no new beat competes
  assign consume_hold = hold_full & commit_en;
  assign load_hold    = accept & ~commit_en;
  assign do_commit    = consume_hold | (accept & commit_en);
  assign commit_entry = hold_full ? held_entry : in_entry;

  assign a_zero = (a_out == '0);

  wb_hold_buffer u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_hold),
    .consume (consume_hold),
    .din     (in_entry),
    .dout    (held_entry),
    .full    (hold_full)
  );

  // Register A: clr_a beats any commit to A on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
    end else if (clr_a) begin
      a_out <= '0;
    end else if (do_commit && dest_writes_a(commit_entry.dest)) begin
      a_out <= commit_entry.data;
    end
  end

  // Register B: written by commits whose destination includes B
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_out <= '0;
    end else if (do_commit && dest_writes_b(commit_entry.dest)) begin
      b_out <= commit_entry.data;
    end
  end

  // Flag register: updated by any commit carrying flags_en, regardless of dest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_out <= '0;
    end else if (do_commit && commit_entry.flags_en) begin
      flags_out <= commit_entry.flags;
    end
  end

  // Commit counter: one per committed beat, including no-op beats; wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_count <= '0;
    end else if (do_commit) begin
      commit_count <= commit_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_regs_ab_writeback.sv
// Scoreboard bench for regs_ab_writeback: directed beats push the expected
// register state after each commit; a monitor pops and compares on commits.
module tb_regs_ab_writeback;

  import regs_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       wb_valid;
  logic       wb_ready;
  logic [7:0] wb_data;
  logic [1:0] wb_dest;
  logic [3:0] wb_flags;
  logic       wb_flags_en;
  logic       commit_en;
  logic       clr_a;
  logic [7:0] a_out;
  logic [7:0] b_out;
  logic [3:0] flags_out;
  logic       a_zero;
  logic       hold_full;
  logic [7:0] commit_count;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] f;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  regs_ab_writeback #(.WIDTH(8), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_data      (wb_data),
    .wb_dest      (wb_dest),
    .wb_flags     (wb_flags),
    .wb_flags_en  (wb_flags_en),
    .commit_en    (commit_en),
    .clr_a        (clr_a),
    .a_out        (a_out),
    .b_out        (b_out),
    .flags_out    (flags_out),
    .a_zero       (a_zero),
    .hold_full    (hold_full),
    .commit_count (commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f, input logic [7:0] cnt);
    exp_q.push_back('{a: a, b: b, f: f, cnt: cnt});
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic [1:0] dest,
                               input logic [3:0] flags, input logic fen, input logic cen, input logic clr);
    wb_valid    = valid;
    wb_data     = data;
    wb_dest     = dest;
    wb_flags    = flags;
    wb_flags_en = fen;
    commit_en   = cen;
    clr_a       = clr;
  endtask

  task automatic stepCycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: a commit happens at an edge where commit_en is high and either a
  // held beat exists or a handshake completes; compare at the following negedge
  always @(posedge clk) begin : monitor
    exp_t e;
    if (rst_n && commit_en && (hold_full || (wb_valid && wb_ready))) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_commit: got commit with count 0x%0h expected none", commit_count);
      end else begin
        e = exp_q.pop_front();
        checkOutput("commit_a_out", a_out, e.a);
        checkOutput("commit_b_out", b_out, e.b);
        checkOutput("commit_flags", flags_out, e.f);
        checkOutput("commit_count", commit_count, e.cnt);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 8'h00, DEST_NONE, 4'h0, 0, 0, 0);
    #12;
    $display("[TB] reset state");
    checkOutput("reset_a_out", a_out, 8'h00);
    checkOutput("reset_b_out", b_out, 8'h00);
    checkOutput("reset_flags", flags_out, 4'h0);
    checkOutput("reset_hold_full", hold_full, 1'b0);
    checkOutput("reset_count", commit_count, 8'h00);
    checkOutput("reset_wb_ready", wb_ready, 1'b0);
    checkOutput("reset_a_zero", a_zero, 1'b1);

    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_release", wb_ready, 1'b1);

    // Direct commit: 0x3C to A with N flag
    $display("[TB] direct commit");
    pushExp(8'h3C, 8'h00, 4'b0100, 8'd1);
    applyStimulus(1, 8'h3C, DEST_A, 4'b0100, 1, 1, 0);
    stepCycle(1);
    applyStimulus(0, 8'h00, DEST_NONE, 4'h0, 0, 1, 0);
    checkOutput("direct_a_out", a_out, 8'h3C);
    checkOutput("direct_ready", wb_ready, 1'b1);
    checkOutput("direct_hold_full", hold_full, 1'b0);

    // Stall and drain: 0xA5 to B parks in the buffer
    $display("[TB] stall and drain");
    applyStimulus(1, 8'hA5, DEST_B, 4'h0, 0, 0, 0);
    stepCycle(1);
    applyStimulus(0, 8'h00, DEST_NONE, 4'h0, 0, 0, 0);
    checkOutput("stall_hold_full", hold_full, 1'b1);
    checkOutput("stall_ready", wb_ready, 1'b0);
    checkOutput("stall_b_unchanged", b_out, 8'h00);
    stepCycle(1);
    checkOutput("stall_hold_persists", hold_full, 1'b1);
    pushExp(8'h3C, 8'hA5, 4'b0100, 8'd2);
    applyStimulus(0, 8'h00, DEST_NONE, 4'h0, 0, 1, 0);
    stepCycle(1);
    applyStimulus(0, 8'h00, DEST_NONE, 4'h0, 0, 0, 0);
    checkOutput("drain_b_out", b_out, 8'hA5);
    checkOutput("drain_hold_clear", hold_full, 1'b0);
    checkOutput("drain_ready", wb_ready, 1'b1);

    // Back-pressure: 0x11 parks, 0x22 waits upstream while ready is low
    $display("[TB] back-pressure ordering");
    applyStimulus(1, 8'h11, DEST_A, 4'h0, 0, 0, 0);
    stepCycle(1);
    applyStimulus(1, 8'h22, DEST_A, 4'h0, 0, 0, 0);
    stepCycle(2);
    checkOutput("bp_hold_full", hold_full, 1'b1);
    checkOutput("bp_ready", wb_ready, 1'b0);
    checkOutput("bp_a_unchanged", a_out, 8'h3C);
    pushExp(8'h11, 8'hA5, 4'b0100, 8'd3);
    pushExp(8'h22, 8'hA5, 4'b0100, 8'd4);
    applyStimulus(1, 8'h22, DEST_A, 4'h0, 0, 1, 0);
    stepCycle(1);
    checkOutput("bp_first_a_out", a_out, 8'h11);
    stepCycle(1);
    applyStimulus(0, 8'h00, DEST_NONE, 4'h0, 0, 1, 0);
    checkOutput("bp_second_a_out", a_out, 8'h22);
    checkOutput("bp_count", commit_count, 8'd4);

    // clr_a collides with a commit of 0x7F to A and B
    $display("[TB] clr_a collision");
    pushExp(8'h00, 8'h7F, 4'b0100, 8'd5);
    applyStimulus(1, 8'h7F, DEST_AB, 4'h0, 0, 1, 1);
    stepCycle(1);
    applyStimulus(0, 8'h00, DEST_NONE, 4'h0, 0, 1, 0);
    checkOutput("clr_a_zero", a_zero, 1'b1);

    pushExp(8'h09, 8'h7F, 4'b0100, 8'd6);
    applyStimulus(1, 8'h09, DEST_A, 4'h0, 0, 1, 0);
    stepCycle(1);
    applyStimulus(0, 8'h00, DEST_NONE, 4'h0, 0, 1, 0);
    checkOutput("a_nonzero_flag", a_zero, 1'b0);

    // clr_a on its own clears A but is not a commit
    applyStimulus(0, 8'h00, DEST_NONE, 4'h0, 0, 1, 1);
    stepCycle(1);
    applyStimulus(0, 8'h00, DEST_NONE, 4'h0, 0, 1, 0);
    checkOutput("clr_only_a_out", a_out, 8'h00);
    checkOutput("clr_only_a_zero", a_zero, 1'b1);
    checkOutput("clr_only_b_out", b_out, 8'h7F);
    checkOutput("clr_only_count", commit_count, 8'd6);

    // Flags written with dest none: Z and V set
    $display("[TB] flags-only beat");
    pushExp(8'h00, 8'h7F, 4'b1001, 8'd7);
    applyStimulus(1, 8'h5A, DEST_NONE, 4'b1001, 1, 1, 0);
    stepCycle(1);
    pushExp(8'h5A, 8'h7F, 4'b1001, 8'd8);
    applyStimulus(1, 8'h5A, DEST_A, 4'b0110, 0, 1, 0);
    stepCycle(1);
    applyStimulus(0, 8'h00, DEST_NONE, 4'h0, 0, 1, 0);
    checkOutput("flags_only_value", flags_out, {1'b1, 1'b0, 1'b0, 1'b1});

    // Counter wrap: 256 no-op commits bring the count back to 8, passing 0
    $display("[TB] counter wrap");
    for (int i = 0; i < 256; i++) begin
      pushExp(8'h5A, 8'h7F, 4'b1001, 8'(9 + i));
    end
    applyStimulus(1, 8'hFF, DEST_NONE, 4'hF, 0, 1, 0);
    stepCycle(256);
    applyStimulus(0, 8'h00, DEST_NONE, 4'h0, 0, 1, 0);
    checkOutput("wrap_count", commit_count, 8'd8);
    checkOutput("wrap_a_out", a_out, 8'h5A);
    checkOutput("wrap_b_out", b_out, 8'h7F);
    checkOutput("wrap_flags", flags_out, 4'b1001);

    // Async reset with a held 0x55: the held beat must vanish
    $display("[TB] async reset with held entry");
    applyStimulus(1, 8'h55, DEST_AB, 4'hF, 1, 0, 0);
    stepCycle(1);
    applyStimulus(0, 8'h00, DEST_NONE, 4'h0, 0, 0, 0);
    checkOutput("pre_reset_hold_full", hold_full, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_a_out", a_out, 8'h00);
    checkOutput("async_b_out", b_out, 8'h00);
    checkOutput("async_flags", flags_out, 4'h0);
    checkOutput("async_hold_full", hold_full, 1'b0);
    checkOutput("async_count", commit_count, 8'h00);
    checkOutput("async_ready", wb_ready, 1'b0);
    stepCycle(1);
    rst_n = 1'b1;
    applyStimulus(0, 8'h00, DEST_NONE, 4'h0, 0, 1, 0);
    stepCycle(3);
    checkOutput("post_reset_a_out", a_out, 8'h00);
    checkOutput("post_reset_b_out", b_out, 8'h00);
    checkOutput("post_reset_flags", flags_out, 4'h0);
    checkOutput("post_reset_count", commit_count, 8'h00);
    checkOutput("post_reset_ready", wb_ready, 1'b1);

    stepCycle(2);
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regs_ab_writeback.md
Name: regs_ab_writeback

Overview:
- Write side of the 8-bit datapath operand registers: accepts ALU results over a valid/ready handshake and commits them into register A and/or register B plus the flag register.
- a_out feeds the A-operand select mux (A or zero); b_out feeds the B-operand path.
- A one-entry holding buffer absorbs a result arriving while commit is stalled.

Parameters:
- WIDTH, 8, data width of A, B and wb_data.
- CNT_W, 8, width of the commit counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wb_valid  input  1  result beat valid.
- wb_ready  output  1  block can accept a beat.
- wb_data  input  WIDTH  result value.
- wb_dest  input  2  destination: 00 none, 01 A, 10 B, 11 A and B.
- wb_flags  input  4  {Z,N,C,V}, Z at bit 3.
- wb_flags_en  input  1  beat updates the flag register.
- commit_en  input  1  commit permitted this cycle (control unit commit phase).
- clr_a  input  1  synchronous clear of register A.
- a_out  output  WIDTH  register A.
- b_out  output  WIDTH  register B.
- flags_out  output  4  flag register.
- a_zero  output  1  combinational (a_out == 0).
- hold_full  output  1  holding buffer occupied.
- commit_count  output  CNT_W  number of committed beats, wraps.

Behaviour:
- Reset (rst_n low, asynchronous): a_out=0, b_out=0, flags_out=0, hold_full=0, commit_count=0, wb_ready=0. After reset is released, wb_ready=1.
- wb_ready = rst_n & !hold_full. It is driven from registered state only, with no combinational path from wb_valid or commit_en.
- A beat is accepted when wb_valid & wb_ready at a rising edge.

Commit rules, evaluated each rising edge in priority order:
1. hold_full & commit_en:
   - Commit the held entry.
   - hold_full clears.
   - No new beat can be accepted this cycle, because wb_ready=0.
2. Accepted beat & commit_en:
   - Commit directly.
   - Write latency is 1 edge: the new value is visible on a_out/b_out after that edge.
3. Accepted beat & !commit_en:
   - Store {data, dest, flags, flags_en} in the holding buffer.
   - hold_full sets, so wb_ready drops the following cycle.
4. Otherwise: no change.

What a commit does:
- Writes A if dest[0] and B if dest[1].
- Writes flags_out if flags_en, independent of dest.
- dest=00 with flags_en=0 is still a commit and increments the counter.
- commit_count increments by 1 per commit and wraps from 2^CNT_W-1 to 0.

clr_a:
- Forces A to 0 on that edge and has priority over any commit to A in the same cycle.
- A B write or flags write in the same commit still happens, and the count still increments.
- clr_a alone does not count as a commit.

Other rules:
- A held entry is never overwritten. The maximum is 1 beat outstanding.
- Data is never dropped or duplicated, and beats commit in arrival order.
- If rst_n is asserted with hold_full=1, the held entry is discarded.
- wb_valid may drop without a handshake; no beat is accepted in that case.
- Upstream must hold wb_data/dest/flags stable while valid & !ready.

Decomposition:
- Shared package regs_pkg:
  - WIDTH.
  - DEST_NONE/DEST_A/DEST_B/DEST_AB encodings.
  - Flag bit indices FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0.
  - Packed writeback entry type {data, dest, flags, flags_en}.
- Sub-module wb_hold_buffer:
  - One-entry buffer with load/consume and full flag, same clk/rst_n.
  - Top level holds the A/B/flag registers, commit mux, clr_a priority and counter.

Test Plan:
- Reset then direct commit: release rst_n; commit_en=1; beat data=0x3C dest=01 flags_en=1 flags=0100 -> after 1 edge a_out=0x3C, b_out=0x00, flags_out=0100, commit_count=1, wb_ready stays 1.
- Stall and drain: commit_en=0; beat 0xA5 dest=10 -> hold_full=1 and wb_ready=0 next cycle, b_out unchanged. Then commit_en=1 -> b_out=0xA5, hold_full=0, and wb_ready=1 on the following cycle.
- Back-pressure ordering: commit_en=0; beats 0x11 then 0x22 to A, with upstream holding 0x22 while ready=0. Then commit_en=1 -> a_out goes 0x11 then 0x22 on successive commits; count +2, with no loss.
- clr_a collision: commit beat 0x7F dest=11 with clr_a=1 in the same cycle -> a_out=0x00, a_zero=1, b_out=0x7F, count +1.
- Counter wrap: perform 256 commits with dest=00 -> commit_count returns to 0; a_out/b_out unchanged.
- Async reset mid-operation: hold_full=1 with held 0x55, pulse rst_n low between edges -> all outputs 0 immediately. After release, the held 0x55 is never committed.
